// File: rtl/rcfg_profile_streamer.sv
// rcfg_profile_streamer: applies one ROM-packed masked-register profile over Avalon-MM reconfig
module rcfg_profile_streamer #(
    parameter int ROM_DATA_WIDTH = 26,
    parameter int ROM_DEPTH      = 4,
    parameter int NUM_PROFILES   = 2,
    parameter int PSEL_W         = 1,
    localparam int AW            = ROM_DEPTH > 1 ? $clog2(ROM_DEPTH) : 1
) (
    input  logic                      reconfig_clk,
    input  logic                      reconfig_reset_n,
    input  logic                      start,
    input  logic [PSEL_W-1:0]         profile_sel,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [AW-1:0]             rom_addr,
    input  logic [ROM_DATA_WIDTH-1:0] rom_data,
    output logic [9:0]                avmm_address,
    output logic                      avmm_read,
    output logic                      avmm_write,
    output logic [31:0]               avmm_writedata,
    input  logic [31:0]               avmm_readdata,
    input  logic                      avmm_waitrequest
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, READ, WRITE, DONE, ERR} state_t;
    state_t state, state_d;
    logic [PSEL_W-1:0] skip_cnt;
    logic [7:0] mask, data;
    logic is_marker, at_last, bad_sel, advance, apply;
    state_t adv_state;
    assign is_marker = &rom_data;
    assign at_last   = rom_addr == AW'(ROM_DEPTH - 1);
    assign bad_sel   = 32'(profile_sel) >= NUM_PROFILES;
    assign advance   = (state == DECODE && skip_cnt != '0) || (state == WRITE && !avmm_waitrequest);
    assign apply     = state == DECODE && skip_cnt == '0 && !is_marker;
    assign adv_state = at_last ? ERR : FETCH;
    assign busy       = state != IDLE;
    assign done       = state == DONE;
    assign avmm_read  = state == READ;
    assign avmm_write = state == WRITE;
    // State register; reset drops any Avalon strobe immediately
    always_ff @(posedge reconfig_clk or negedge reconfig_reset_n) begin
        if (!reconfig_reset_n) state <= IDLE;
        else state <= state_d;
    end
    // Next-state: walk the ROM, skipping whole profiles, and RMW each selected entry
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = start ? (bad_sel ? ERR : FETCH) : IDLE;
            FETCH:   state_d = DECODE;
            DECODE:  state_d = advance ? adv_state : (is_marker ? DONE : READ);
            READ:    state_d = avmm_waitrequest ? READ : WRITE;
            WRITE:   state_d = avmm_waitrequest ? WRITE : adv_state;
            default: state_d = IDLE;
        endcase
    end
    // Datapath: ROM pointer, profile skip count, latched entry, merged write data, sticky error
    always_ff @(posedge reconfig_clk or negedge reconfig_reset_n) begin
        if (!reconfig_reset_n) begin
            rom_addr       <= '0;
            skip_cnt       <= '0;
            mask           <= '0;
            data           <= '0;
            avmm_address   <= '0;
            avmm_writedata <= '0;
            error          <= 1'b0;
        end else begin
            if (state == IDLE && start && !bad_sel) begin
                rom_addr <= '0;
                skip_cnt <= profile_sel;
                error    <= 1'b0;
            end
            if (state == DECODE && is_marker && skip_cnt != '0) skip_cnt <= skip_cnt - 1'b1;
            if (apply) {avmm_address, mask, data} <= rom_data[25:0];
            if (advance && !at_last) rom_addr <= rom_addr + 1'b1;
            if (state == READ && !avmm_waitrequest)
                avmm_writedata <= {avmm_readdata[31:8], (avmm_readdata[7:0] & ~mask) | (data & mask)};
            if (state == ERR) error <= 1'b1;
        end
    end
endmodule
